mod_counter_ctrl: RTL

//  Programmable modulo-N up/down counter with one-shot/auto-reload run control.

---
 rtl/mod_counter_pkg.sv | 10 +
 rtl/mod_counter_ctrl_dff.sv | 11 +
 rtl/mod_counter_ctrl.sv | 63 ++++++
 3 files changed

// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: FSM encoding, per-edge action priority and mode constants for mod_counter_ctrl.
package mod_counter_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
   typedef enum logic [1:0] {ACT_HOLD, ACT_STEP, ACT_LOAD, ACT_START} act_t;
   localparam logic DIR_UP       = 1'b1;
   localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/mod_counter_ctrl_dff.sv
// dff: single bit cell with asynchronous active-low clear.
module dff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= 1'b0;
      else q <= d;
endmodule

// File: rtl/mod_counter_ctrl.sv
// mod_counter_ctrl: modulo-N up/down counter with one-shot/auto-reload run control.
// Define MOD_COUNTER_GRAY_OUT_EN to add a registered gray_count output.
module mod_counter_ctrl
   import mod_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             en,
   input  logic             up,
   input  logic             oneshot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] modulus,
`ifdef MOD_COUNTER_GRAY_OUT_EN
   output logic [WIDTH-1:0] gray_count,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy,
   output logic             done
);
   state_t           state, state_d;
   act_t             act;
   logic [WIDTH-1:0] count_d, wrap, nxt, clamp;
   logic             term, tc_d;
   always_comb begin
      act     = start ? ACT_START : load ? ACT_LOAD : (state == RUN && en) ? ACT_STEP : ACT_HOLD;
      term    = (up == DIR_UP) ? (count >= modulus) : (count == '0);
      wrap    = (up == DIR_UP) ? '0 : modulus;
      nxt     = (up == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
      clamp   = (load_val > modulus) ? modulus : load_val;
      count_d = act == ACT_START ? wrap :
                act == ACT_LOAD  ? clamp :
                act == ACT_STEP  ? (term ? (oneshot == MODE_ONESHOT ? count : wrap) : nxt) : count;
      // a oneshot terminal step parks the run; everything else keeps the state unless restarted
      state_d = act == ACT_START ? RUN :
                (act == ACT_STEP && term && oneshot == MODE_ONESHOT) ? DONE : state;
      tc_d    = act == ACT_STEP && term;
   end
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff u_dff (.clk(clk), .rst_n(rst_n), .d(count_d[i]), .q(count[i]));
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         tc    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         tc    <= tc_d;
         busy  <= state_d == RUN;
         done  <= state_d == DONE;
      end
`ifdef MOD_COUNTER_GRAY_OUT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) gray_count <= '0;
      else gray_count <= count ^ (count >> 1);
`endif
endmodule
